// File: rtl/clock_text_writer.sv
// clock_text_writer: renders the clock time as "MM:SS.d" into the text RAM, one handshaked beat per character.
module clock_text_writer #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        dsec,
  input  logic [5:0]        sec,
  input  logic [5:0]        min,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;
  state_t state, state_n;
  logic [5:0] min_s, sec_s, min_l, sec_l, min_w, sec_w, digit;
  logic [3:0] dsec_s, dsec_l, dsec_d;
  logic [2:0] min_t, sec_t, cnt, k;
  logic force_r, changed;
  assign changed = force_r || {min, sec, dsec} != {min_l, sec_l, dsec_l};
  assign dsec_d = dsec_s > 4'd9 ? 4'd9 : dsec_s;
  always_comb begin
    state_n = state == IDLE ? (changed ? CONV : IDLE) :
              state == CONV ? (cnt == 3'd5 ? WRITE : CONV) :
              (wr_ready && k == 3'd6 ? IDLE : WRITE);
    wr_en = state == WRITE;
    busy = state != IDLE;
    wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(k);
    digit = k == 3'd0 ? {3'b000, min_t} :
            k == 3'd1 ? min_w :
            k == 3'd3 ? {3'b000, sec_t} :
            k == 3'd4 ? sec_w : {2'b00, dsec_d};
    wr_data = !wr_en ? 8'h00 : k == 3'd2 ? 8'h3A : k == 3'd5 ? 8'h2E : 8'h30 + {2'b00, digit};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Working values become the units digits after six conditional subtract-10 steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {min_s, sec_s, dsec_s, min_l, sec_l, dsec_l} <= '0;
      {min_w, sec_w, min_t, sec_t, cnt, k} <= '0;
      force_r <= 1'b1;
    end else if (state == IDLE) begin
      if (changed) begin
        {min_s, sec_s, dsec_s} <= {min, sec, dsec};
        {min_w, sec_w} <= {min, sec};
        {min_t, sec_t, cnt, k} <= '0;
        force_r <= 1'b0;
      end
    end else if (state == CONV) begin
      min_w <= min_w >= 6'd10 ? min_w - 6'd10 : min_w;
      min_t <= min_w >= 6'd10 ? min_t + 3'd1 : min_t;
      sec_w <= sec_w >= 6'd10 ? sec_w - 6'd10 : sec_w;
      sec_t <= sec_w >= 6'd10 ? sec_t + 3'd1 : sec_t;
      cnt <= cnt + 3'd1;
    end else if (wr_ready) begin
      k <= k == 3'd6 ? 3'd0 : k + 3'd1;
      if (k == 3'd6) {min_l, sec_l, dsec_l} <= {min_s, sec_s, dsec_s};
    end
  end
endmodule

// File: tb/tb_clock_text_writer.sv
// tb_clock_text_writer: directed and random renders checked against an arithmetic model of the "MM:SS.d" string.
module tb_clock_text_writer;
  logic clk = 1'b0, reset = 1'b1, rdy = 1'b1;
  logic [5:0] min_i = '0, sec_i = '0;
  logic [3:0] dsec_i = '0;
  logic we0, we1, busy0, busy1;
  logic [11:0] a0, a1;
  logic [7:0] d0, d1;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  clock_text_writer u0 (.clk(clk), .reset(reset), .dsec(dsec_i), .sec(sec_i), .min(min_i),
    .wr_ready(rdy), .wr_en(we0), .wr_addr(a0), .wr_data(d0), .busy(busy0));
  clock_text_writer #(.BASE_ADDR(100)) u1 (.clk(clk), .reset(reset), .dsec(dsec_i), .sec(sec_i),
    .min(min_i), .wr_ready(rdy), .wr_en(we1), .wr_addr(a1), .wr_data(d1), .busy(busy1));

  function automatic logic [7:0] ch(input int m, s, d, k);
    case (k)
      0: return 8'(48 + m / 10);
      1: return 8'(48 + m % 10);
      2: return 8'h3A;
      3: return 8'(48 + s / 10);
      4: return 8'(48 + s % 10);
      5: return 8'h2E;
      default: return 8'(48 + (d > 9 ? 9 : d));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // evt: 0 none, 1 change sec to 4 at beat 2, 2 assert reset at beat 4 with ready low
  task automatic render(input int m, s, d, mode, evt);
    int lat, cyc, st, n;
    lat = 0;
    while (!busy0 && lat < 40) begin @(negedge clk); lat++; end
    chk("busy_rise", busy0, 1);
    lat = 0;
    while (!we0 && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", lat, 6);
    cyc = 0;
    st = 0;
    for (int k = 0; k < 7; k++) begin
      if (evt == 1 && k == 2) sec_i = 6'd4;
      if (evt == 2 && k == 4) begin
        rdy = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_wr_en", we0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_addr_u1", a1, 100);
        chk("rst_data", d0, 0);
        @(negedge clk);
        reset = 1'b0;
        rdy = 1'b1;
        return;
      end
      n = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2));
      for (int i = 0; i <= n; i++) begin
        rdy = (i == n);
        chk("beat_en", {we0, we1}, 2'b11);
        chk("beat_addr_u0", a0, k);
        chk("beat_addr_u1", a1, 100 + k);
        chk("beat_data_u0", d0, ch(m, s, d, k));
        chk("beat_data_u1", d1, ch(m, s, d, k));
        @(negedge clk);
        cyc++;
      end
      st += n;
    end
    chk("done_wr_en", we0, 0);
    chk("done_busy", busy0, 0);
    chk("cycles", cyc, 7 + st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vec);
    $fatal(1, "timeout");
  end

  initial begin
    int n, m, s, d, lm, ls, ld;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", we0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_addr_u0", a0, 0);
    chk("reset_addr_u1", a1, 100);
    chk("reset_data", d0, 0);
    reset = 1'b0;
    render(0, 0, 0, 0, 0);
    n = 0;
    repeat (50) begin @(negedge clk); n += int'(we0 | we1 | busy0); end
    chk("idle_quiet", n, 0);
    min_i = 6'd59; sec_i = 6'd59; dsec_i = 4'd9;
    render(59, 59, 9, 0, 0);
    min_i = 6'd7; sec_i = 6'd3; dsec_i = 4'd5;
    render(7, 3, 5, 1, 0);
    dsec_i = 4'd6;
    render(7, 3, 6, 0, 1);
    render(7, 4, 6, 0, 0);
    min_i = 6'd12; sec_i = 6'd34; dsec_i = 4'd5;
    render(12, 34, 5, 0, 2);
    render(12, 34, 5, 0, 0);
    min_i = 6'd63; sec_i = 6'd60; dsec_i = 4'd12;
    render(63, 60, 12, 0, 0);
    n = 0;
    repeat (20) begin @(negedge clk); n += int'(we0 | busy0); end
    chk("unchanged_quiet", n, 0);
    lm = 63; ls = 60; ld = 12;
    repeat (10) begin
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      d = (ld + 1 + int'($urandom_range(0, 14))) % 16;
      min_i = 6'(m); sec_i = 6'(s); dsec_i = 4'(d);
      render(m, s, d, 2, 0);
      lm = m; ls = s; ld = d;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/clock_text_writer.md
# clock_text_writer

Renders the running clock value (minutes, seconds, tenths) into the VGA text buffer as the seven-character string "MM:SS.d". Sits between the clock counter block and the text-RAM write port, on the write side of the buffer that the VGA character scanner reads. Each new time value is captured, converted to ASCII digits, and written one character per accepted write beat. Writes use a valid/ready handshake so the text-RAM arbiter can stall them.

## Interface
- BASE_ADDR, 0: text-RAM address of the first character ('M' tens digit).
- ADDR_W, 12: width of the text-RAM address (80x30 = 2400 cells fit).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dsec  in  4  tenths of a second, 0..9 nominal.
- sec  in  6  seconds, 0..59 nominal.
- min  in  6  minutes, 0..59 nominal.
- wr_ready  in  1  text RAM accepts the current beat this cycle.
- wr_en  out  1  write beat valid.
- wr_addr  out  ADDR_W  character cell address.
- wr_data  out  8  ASCII character code.
- busy  out  1  high while a snapshot is being converted or written.

## Operation
- States: IDLE, CONV, WRITE.
- Registers: snapshot {min_s, sec_s, dsec_s}, last-rendered {min_l, sec_l, dsec_l}, a force flag, a conversion counter (0..5), and a beat index (0..6).
- Reset: force=1, last=0, state IDLE, counters 0.
- IDLE: on any edge where force=1 or {min,sec,dsec} differs from last:
  - capture the inputs into the snapshot;
  - clear force;
  - go to CONV.
- CONV: exactly 6 cycles. Each cycle, subtract 10 from the min and sec working values in parallel where the value is >= 10, incrementing that value's tens counter.
  - The working value left over is the units digit; tens ranges 0..6.
  - min/sec inputs 60..63 render tens '6' with the correct units digit.
  - dsec > 9 renders '9'.
- WRITE: beat k (0..6) presents:
  - wr_addr = BASE_ADDR+k, truncated to ADDR_W;
  - wr_data = min tens, min units, 0x3A ':', sec tens, sec units, 0x2E '.', dsec digit;
  - digit character = 0x30 + value.
- A beat transfers on an edge with wr_en=1 and wr_ready=1, then k advances.
- While wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data hold stable.
- After beat 6 transfers: last ← snapshot, wr_en drops, state → IDLE.
- Input changes during CONV or WRITE are ignored for the current snapshot. IDLE compares the inputs against last on the cycle after returning and re-renders if they differ. Intermediate values may be skipped; the final value is always rendered.

## Timing
- Reset values: wr_en=0, wr_addr=BASE_ADDR, wr_data=0x00, busy=0.
- The assertion of reset forces these values asynchronously, mid-beat included. Any partially written string is not completed; it is re-rendered in full after reset because force=1.
- Snapshot edge E: busy=1 from E. wr_en rises at edge E+6 with beat 0.
- With wr_ready held high, beats transfer at edges E+7..E+13. wr_en=0 and busy=0 after edge E+13.
- Earliest next snapshot is edge E+14, giving a minimum interval of 14 cycles between renders.
- Each wr_ready=0 cycle during WRITE delays completion by exactly one cycle.
- Outputs are registered; there is no combinational path from wr_ready or the time inputs to any output.
- busy is low in IDLE.

## Test plan
- Reset, then idle with inputs 0, wr_ready=1:
  - After reset, the seven beats transfer at edges E+7..E+13.
  - Required writes: addr 0..6 ← 30 30 3A 30 30 2E 30.
  - Then no further wr_en for 50 cycles.
- Set min=59, sec=59, dsec=9 after the first render:
  - Required writes: 35 39 3A 35 39 2E 39.
  - Latency from snapshot edge to wr_en is exactly 6 cycles.
- BASE_ADDR=100, wr_ready toggled 1/0 every cycle, min=7, sec=3, dsec=5:
  - Required writes: addr 100..106 ← 30 37 3A 30 33 2E 35.
  - wr_addr and wr_data stay stable through each stall; 7 stall cycles are added.
- Change sec from 3 to 4 at beat 2 of a render:
  - The current string completes with sec 03.
  - A second render follows writing 30 34 at addr 3..4 (full 7 beats).
- Assert reset during beat 4 with wr_ready=0:
  - wr_en=0 and busy=0 immediately.
  - After release, a full 7-beat render of the current inputs occurs.
- Inputs min=63, sec=60, dsec=12:
  - Required writes: 36 33 3A 36 30 2E 39.
